tank_bullet: RTL and testbench

Generates, moves and retires one bullet fired by a tank, player or enemy. It drives the x/y bullet coordinates consumed by the eagle, tank and enemy collision checks, and per-pixel on-flags for the pixel mux. One instance per shooter (player, enemy 1..3). Motion advances once per frame on refresh_tick. An external hit input or leaving the play field retires the bullet through a short explosion phase.

---
 rtl/tank_pkg.sv | 30 +++
 rtl/bullet_step.sv | 64 ++++++
 rtl/tank_bullet.sv | 230 +++++++++++++++++++++++
 tb/tb_tank_bullet.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and field geometry for the tank game blocks.
// Holds the facing-direction enum, the bullet life-cycle states and the
// play-field / sprite dimensions. No ports; imported by the bullet logic.
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLY   = 2'd1,
        S_BURST = 2'd2,
        S_COOL  = 2'd3
    } bullet_state_t;

    localparam int FIELD_W     = 640;
    localparam int FIELD_H     = 480;
    localparam int TILE_SIZE   = 32;
    localparam int BULLET_SIZE = 4;

    // A bullet leaves from the middle of the tile side it faces.
    localparam int SPAWN_MID   = (TILE_SIZE - BULLET_SIZE) / 2;
    // Offset of the last bullet-sized slot inside a tile (bottom/right edge).
    localparam int SPAWN_FAR   = TILE_SIZE - BULLET_SIZE;

endpackage

// File: rtl/bullet_step.sv
// Combinational one-step mover for a 4x4 bullet box.
// Ports:
//   pos_x_i/pos_y_i : current box top-left corner
//   dir_i           : direction of travel (dir_t encoding)
//   step_i          : pixels to move (1..8)
//   next_x_o/y_o    : moved corner (only meaningful when oob_o is 0)
//   oob_o           : the move would leave the play field
// The bound test is made on the unmoved position with 11-bit sums, so the
// subtraction for up/left can never wrap into a bogus in-field value.
module bullet_step
    import tank_pkg::*;
(
    input  logic [9:0] pos_x_i,
    input  logic [9:0] pos_y_i,
    input  logic [1:0] dir_i,
    input  logic [3:0] step_i,
    output logic [9:0] next_x_o,
    output logic [9:0] next_y_o,
    output logic       oob_o
);

    logic [10:0] pos_x_w;
    logic [10:0] pos_y_w;
    logic [10:0] step_w;
    logic [10:0] far_x_w;
    logic [10:0] far_y_w;
    logic [9:0]  step10_w;

    assign pos_x_w  = {1'b0, pos_x_i};
    assign pos_y_w  = {1'b0, pos_y_i};
    assign step_w   = {7'd0, step_i};
    assign step10_w = {6'd0, step_i};
    // Far edge of the box after the move, for down/right bound tests.
    assign far_x_w  = pos_x_w + 11'(BULLET_SIZE) + step_w;
    assign far_y_w  = pos_y_w + 11'(BULLET_SIZE) + step_w;

    always_comb begin
        next_x_o = pos_x_i;
        next_y_o = pos_y_i;
        oob_o    = 1'b0;
        case (dir_t'(dir_i))
            UP: begin
                oob_o    = (pos_y_w < step_w);
                next_y_o = pos_y_i - step10_w;
            end
            DOWN: begin
                oob_o    = (far_y_w > 11'(FIELD_H));
                next_y_o = pos_y_i + step10_w;
            end
            LEFT: begin
                oob_o    = (pos_x_w < step_w);
                next_x_o = pos_x_i - step10_w;
            end
            RIGHT: begin
                oob_o    = (far_x_w > 11'(FIELD_W));
                next_x_o = pos_x_i + step10_w;
            end
            default: begin
                oob_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tank_bullet.sv
// One tank's bullet: spawn on fire, fly once per frame, explode, cool down.
// Ports:
//   clk_50MHz, reset      : clock, async active-high reset
//   refresh_tick          : one-cycle frame pulse, paces motion and timers
//   fire                  : fire request, honoured only in IDLE
//   x_shooter/y_shooter   : shooter tile top-left, dir_shooter its facing
//   hit                   : a consumer saw the bullet collide (FLY only)
//   x, y                  : VGA pixel being drawn
//   x_bullet/y_bullet     : bullet box corner (impact point during BURST,
//                           parked coordinates in IDLE/COOL)
//   bullet_active         : high while flying
//   bullet_on / burst_on  : pixel lies in the bullet / explosion box
//   shot_fired            : one-cycle pulse when a bullet spawns
module tank_bullet
    import tank_pkg::*;
#(
    parameter int         SPEED          = 4,
    parameter int         BURST_TICKS    = 8,
    parameter int         COOLDOWN_TICKS = 16,
    parameter logic [9:0] PARK_X         = 10'd0,
    parameter logic [9:0] PARK_Y         = 10'd0
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       fire,
    input  logic [9:0] x_shooter,
    input  logic [9:0] y_shooter,
    input  logic [1:0] dir_shooter,
    input  logic       hit,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [9:0] x_bullet,
    output logic [9:0] y_bullet,
    output logic       bullet_active,
    output logic       bullet_on,
    output logic       burst_on,
    output logic       shot_fired
);

    localparam logic [7:0] BURST_LAST = 8'(BURST_TICKS - 1);
    localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN_TICKS - 1);

    bullet_state_t state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    dir_q, dir_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          shot_q, shot_d;

    logic [9:0]    base_x, base_y;
    logic [9:0]    clamp_x, clamp_y;
    logic [9:0]    spawn_x, spawn_y;
    logic          spawn_oob;
    logic [9:0]    move_x, move_y;
    logic          move_oob;

    // The spawn point is found by stepping BULLET_SIZE pixels out of the
    // shooter tile from the slot touching the facing side, which reuses
    // the mover's bound check for spawn under/overflow. On overflow the
    // explosion is pinned to the field edge the shooter was facing.
    always_comb begin
        base_x  = x_shooter;
        base_y  = y_shooter;
        clamp_x = x_shooter;
        clamp_y = y_shooter;
        case (dir_t'(dir_shooter))
            UP: begin
                base_x  = x_shooter + 10'(SPAWN_MID);
                clamp_x = base_x;
                clamp_y = 10'd0;
            end
            DOWN: begin
                base_x  = x_shooter + 10'(SPAWN_MID);
                base_y  = y_shooter + 10'(SPAWN_FAR);
                clamp_x = base_x;
                clamp_y = 10'(FIELD_H - BULLET_SIZE);
            end
            LEFT: begin
                base_y  = y_shooter + 10'(SPAWN_MID);
                clamp_x = 10'd0;
                clamp_y = base_y;
            end
            RIGHT: begin
                base_x  = x_shooter + 10'(SPAWN_FAR);
                base_y  = y_shooter + 10'(SPAWN_MID);
                clamp_x = 10'(FIELD_W - BULLET_SIZE);
                clamp_y = base_y;
            end
            default: begin
                base_x = x_shooter;
            end
        endcase
    end

    bullet_step u_spawn_step (
        .pos_x_i  (base_x),
        .pos_y_i  (base_y),
        .dir_i    (dir_shooter),
        .step_i   (4'(BULLET_SIZE)),
        .next_x_o (spawn_x),
        .next_y_o (spawn_y),
        .oob_o    (spawn_oob)
    );

    bullet_step u_move_step (
        .pos_x_i  (x_q),
        .pos_y_i  (y_q),
        .dir_i    (dir_q),
        .step_i   (4'(SPEED)),
        .next_x_o (move_x),
        .next_y_o (move_y),
        .oob_o    (move_oob)
    );

    // State and datapath registers; reset parks the bullet immediately.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= PARK_X;
            y_q     <= PARK_Y;
            dir_q   <= 2'd0;
            cnt_q   <= 8'd0;
            shot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            shot_q  <= shot_d;
        end
    end

    // Next-state logic. In FLY a hit wins over the frame move, and an
    // out-of-bounds move enters BURST without moving. The shared counter
    // restarts on every state change and counts frames in BURST and COOL.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        shot_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    dir_d  = dir_shooter;
                    shot_d = 1'b1;
                    cnt_d  = 8'd0;
                    if (spawn_oob) begin
                        state_d = S_BURST;
                        x_d     = clamp_x;
                        y_d     = clamp_y;
                    end else begin
                        state_d = S_FLY;
                        x_d     = spawn_x;
                        y_d     = spawn_y;
                    end
                end
            end
            S_FLY: begin
                if (hit) begin
                    state_d = S_BURST;
                    cnt_d   = 8'd0;
                end else if (refresh_tick) begin
                    if (move_oob) begin
                        state_d = S_BURST;
                        cnt_d   = 8'd0;
                    end else begin
                        x_d = move_x;
                        y_d = move_y;
                    end
                end
            end
            S_BURST: begin
                if (refresh_tick) begin
                    if (cnt_q == BURST_LAST) begin
                        state_d = S_COOL;
                        cnt_d   = 8'd0;
                        x_d     = PARK_X;
                        y_d     = PARK_Y;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_COOL: begin
                if (refresh_tick) begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic [10:0] px_w, py_w, bx_w, by_w;
    logic [10:0] burst_lo_x, burst_lo_y;

    assign px_w       = {1'b0, x};
    assign py_w       = {1'b0, y};
    assign bx_w       = {1'b0, x_q};
    assign by_w       = {1'b0, y_q};
    // Explosion box starts 6 pixels up/left of the impact, floored at 0.
    assign burst_lo_x = (bx_w < 11'd6) ? 11'd0 : bx_w - 11'd6;
    assign burst_lo_y = (by_w < 11'd6) ? 11'd0 : by_w - 11'd6;

    // Output decode from registered state and the current pixel.
    always_comb begin
        bullet_active = (state_q == S_FLY);
        bullet_on     = (state_q == S_FLY)
                        && (px_w >= bx_w) && (px_w <= bx_w + 11'd3)
                        && (py_w >= by_w) && (py_w <= by_w + 11'd3);
        burst_on      = (state_q == S_BURST)
                        && (px_w >= burst_lo_x) && (px_w <= bx_w + 11'd9)
                        && (py_w >= burst_lo_y) && (py_w <= by_w + 11'd9);
    end

    assign x_bullet   = x_q;
    assign y_bullet   = y_q;
    assign shot_fired = shot_q;

endmodule

// File: tb/tb_tank_bullet.sv
// Self-checking bench for tank_bullet: a hand-derived vector table, a few
// hand-written multi-cycle sequences, then randomized traffic compared
// against a frame-level reference model of the bullet's life cycle.
module tb_tank_bullet;

    localparam int SPEED          = 4;
    localparam int BURST_TICKS    = 8;
    localparam int COOLDOWN_TICKS = 16;
    localparam int PARK_X         = 0;
    localparam int PARK_Y         = 0;

    localparam int PH_IDLE  = 0;
    localparam int PH_FLY   = 1;
    localparam int PH_BURST = 2;
    localparam int PH_COOL  = 3;

    logic       clk_50MHz;
    logic       reset;
    logic       refresh_tick;
    logic       fire;
    logic [9:0] x_shooter;
    logic [9:0] y_shooter;
    logic [1:0] dir_shooter;
    logic       hit;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] x_bullet;
    logic [9:0] y_bullet;
    logic       bullet_active;
    logic       bullet_on;
    logic       burst_on;
    logic       shot_fired;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model: phase, impact/flight position, heading, frame count.
    int mPhase;
    int mX;
    int mY;
    int mDir;
    int mCnt;
    int mShot;

    tank_bullet #(
        .SPEED          (SPEED),
        .BURST_TICKS    (BURST_TICKS),
        .COOLDOWN_TICKS (COOLDOWN_TICKS),
        .PARK_X         (10'(PARK_X)),
        .PARK_Y         (10'(PARK_Y))
    ) dut (
        .clk_50MHz     (clk_50MHz),
        .reset         (reset),
        .refresh_tick  (refresh_tick),
        .fire          (fire),
        .x_shooter     (x_shooter),
        .y_shooter     (y_shooter),
        .dir_shooter   (dir_shooter),
        .hit           (hit),
        .x             (x),
        .y             (y),
        .x_bullet      (x_bullet),
        .y_bullet      (y_bullet),
        .bullet_active (bullet_active),
        .bullet_on     (bullet_on),
        .burst_on      (burst_on),
        .shot_fired    (shot_fired)
    );

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    typedef struct {
        logic       f;
        logic       t;
        logic       h;
        logic [9:0] xs;
        logic [9:0] ys;
        logic [1:0] d;
        logic [9:0] px;
        logic [9:0] py;
        int         pre;
        int         ex;
        int         ey;
        int         eact;
        int         eshot;
        int         eon;
        int         eburst;
    } vec_t;

    vec_t tbl[8];

    task automatic checkVal(input string name, input int act, input int exp);
        vecCount++;
        if (act != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = PH_IDLE;
        mX     = PARK_X;
        mY     = PARK_Y;
        mDir   = 0;
        mCnt   = 0;
        mShot  = 0;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic modelEdge();
        int sx;
        int sy;
        int nx;
        int ny;
        bit bad;
        mShot = 0;
        case (mPhase)
            PH_IDLE: begin
                if (fire) begin
                    mShot = 1;
                    mDir  = int'(dir_shooter);
                    mCnt  = 0;
                    sx    = int'(x_shooter);
                    sy    = int'(y_shooter);
                    bad   = 0;
                    case (mDir)
                        0: begin sx += 14; sy -= 4;  if (sy < 0)       begin bad = 1; sy = 0;   end end
                        1: begin sx += 14; sy += 32; if (sy + 4 > 480) begin bad = 1; sy = 476; end end
                        2: begin sx -= 4;  sy += 14; if (sx < 0)       begin bad = 1; sx = 0;   end end
                        default: begin sx += 32; sy += 14; if (sx + 4 > 640) begin bad = 1; sx = 636; end end
                    endcase
                    mX     = sx % 1024;
                    mY     = sy % 1024;
                    mPhase = bad ? PH_BURST : PH_FLY;
                end
            end
            PH_FLY: begin
                if (hit) begin
                    mPhase = PH_BURST;
                    mCnt   = 0;
                end else if (refresh_tick) begin
                    nx  = mX;
                    ny  = mY;
                    bad = 0;
                    case (mDir)
                        0: begin ny -= SPEED; bad = (ny < 0);       end
                        1: begin ny += SPEED; bad = (ny + 4 > 480); end
                        2: begin nx -= SPEED; bad = (nx < 0);       end
                        default: begin nx += SPEED; bad = (nx + 4 > 640); end
                    endcase
                    if (bad) begin
                        mPhase = PH_BURST;
                        mCnt   = 0;
                    end else begin
                        mX = nx;
                        mY = ny;
                    end
                end
            end
            PH_BURST: begin
                if (refresh_tick) begin
                    mCnt++;
                    if (mCnt == BURST_TICKS) begin
                        mPhase = PH_COOL;
                        mCnt   = 0;
                        mX     = PARK_X;
                        mY     = PARK_Y;
                    end
                end
            end
            default: begin
                if (refresh_tick) begin
                    mCnt++;
                    if (mCnt == COOLDOWN_TICKS) begin
                        mPhase = PH_IDLE;
                        mCnt   = 0;
                    end
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs, update the model and sample 1 time unit
    // after the clock edge.
    task automatic applyStimulus(input logic f, input logic t, input logic h,
                                 input logic [9:0] xs, input logic [9:0] ys,
                                 input logic [1:0] d,
                                 input logic [9:0] px, input logic [9:0] py);
        fire         = f;
        refresh_tick = t;
        hit          = h;
        x_shooter    = xs;
        y_shooter    = ys;
        dir_shooter  = d;
        x            = px;
        y            = py;
        modelEdge();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        int lox;
        int loy;
        int expOn;
        int expBurst;
        lox      = (mX >= 6) ? mX - 6 : 0;
        loy      = (mY >= 6) ? mY - 6 : 0;
        expOn    = (mPhase == PH_FLY && int'(x) >= mX && int'(x) <= mX + 3
                    && int'(y) >= mY && int'(y) <= mY + 3) ? 1 : 0;
        expBurst = (mPhase == PH_BURST && int'(x) >= lox && int'(x) <= mX + 9
                    && int'(y) >= loy && int'(y) <= mY + 9) ? 1 : 0;
        checkVal({tag, ".x_bullet"}, int'(x_bullet), mX);
        checkVal({tag, ".y_bullet"}, int'(y_bullet), mY);
        checkVal({tag, ".active"}, int'(bullet_active), (mPhase == PH_FLY) ? 1 : 0);
        checkVal({tag, ".shot"}, int'(shot_fired), mShot);
        checkVal({tag, ".bullet_on"}, int'(bullet_on), expOn);
        checkVal({tag, ".burst_on"}, int'(burst_on), expBurst);
    endtask

    task automatic tickCycle(input string tag);
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd320, 10'd300, 2'd0, 10'(mX), 10'(mY));
        checkOutput(tag);
    endtask

    // Tick until the model is idle again, bounded so the run always ends.
    task automatic drainToIdle(input string tag);
        int n;
        n = 0;
        while (mPhase != PH_IDLE && n < 300) begin
            tickCycle(tag);
            n++;
        end
        checkVal({tag, ".drained"}, (mPhase == PH_IDLE) ? 1 : 0, 1);
    endtask

    initial begin
        int shots;
        int actSeen;
        logic [9:0] rxs;
        logic [9:0] rys;
        logic [9:0] rpx;
        logic [9:0] rpy;
        int pxi;
        int pyi;

        //        f  t  h  xs   ys   d  px   py   pre ex   ey   act sh on bu
        tbl[0] = '{1, 0, 0, 320, 300, 0, 334, 296, 0,  334, 296, 1,  1, 1, 0};
        tbl[1] = '{0, 1, 0, 320, 300, 0, 333, 292, 0,  334, 292, 1,  0, 0, 0};
        tbl[2] = '{0, 1, 0, 320, 300, 0, 337, 291, 0,  334, 288, 1,  0, 1, 0};
        tbl[3] = '{0, 1, 0, 320, 300, 0, 338, 284, 0,  334, 284, 1,  0, 0, 0};
        tbl[4] = '{0, 1, 1, 320, 300, 0, 328, 278, 0,  334, 284, 0,  0, 0, 1};
        tbl[5] = '{1, 0, 0, 320, 300, 1, 334, 332, 24, 334, 332, 1,  1, 1, 0};
        tbl[6] = '{0, 1, 1, 320, 300, 1, 328, 326, 0,  334, 332, 0,  0, 0, 1};
        tbl[7] = '{0, 0, 0, 320, 300, 1, 327, 326, 0,  334, 332, 0,  0, 0, 0};

        reset        = 1'b1;
        fire         = 1'b0;
        refresh_tick = 1'b0;
        hit          = 1'b0;
        x_shooter    = 10'd0;
        y_shooter    = 10'd0;
        dir_shooter  = 2'd0;
        x            = 10'd0;
        y            = 10'd0;
        modelReset();
        #2;
        checkOutput("reset");
        @(posedge clk_50MHz);
        #1;
        reset = 1'b0;

        // Up spawn/move and hit priority from the table.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < tbl[i].pre; k++) tickCycle("pre");
            applyStimulus(tbl[i].f, tbl[i].t, tbl[i].h, tbl[i].xs, tbl[i].ys,
                          tbl[i].d, tbl[i].px, tbl[i].py);
            checkVal($sformatf("tbl%0d.x", i), int'(x_bullet), tbl[i].ex);
            checkVal($sformatf("tbl%0d.y", i), int'(y_bullet), tbl[i].ey);
            checkVal($sformatf("tbl%0d.active", i), int'(bullet_active), tbl[i].eact);
            checkVal($sformatf("tbl%0d.shot", i), int'(shot_fired), tbl[i].eshot);
            checkVal($sformatf("tbl%0d.bullet_on", i), int'(bullet_on), tbl[i].eon);
            checkVal($sformatf("tbl%0d.burst_on", i), int'(burst_on), tbl[i].eburst);
        end
        drainToIdle("drain1");

        // Top boundary, burst hold, cooldown length.
        applyStimulus(1, 0, 0, 100, 8, 0, 0, 0);
        checkVal("top.spawn_x", int'(x_bullet), 114);
        checkVal("top.spawn_y", int'(y_bullet), 4);
        checkVal("top.spawn_shot", int'(shot_fired), 1);
        applyStimulus(0, 1, 0, 100, 8, 0, 0, 0);
        checkVal("top.tick1_y", int'(y_bullet), 0);
        checkVal("top.tick1_active", int'(bullet_active), 1);
        applyStimulus(0, 1, 0, 100, 8, 0, 0, 0);
        checkVal("top.burst_x", int'(x_bullet), 114);
        checkVal("top.burst_y", int'(y_bullet), 0);
        checkVal("top.burst_active", int'(bullet_active), 0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 1, 0, 100, 8, 0, 0, 0);
            checkVal("top.burst_hold_x", int'(x_bullet), 114);
        end
        applyStimulus(0, 1, 0, 100, 8, 0, 0, 0);
        checkVal("top.cool_x", int'(x_bullet), 0);
        checkVal("top.cool_y", int'(y_bullet), 0);
        for (int k = 0; k < 15; k++) tickCycle("top.cool");
        applyStimulus(1, 0, 0, 100, 8, 0, 0, 0);
        checkVal("top.cool_fire_ignored", int'(shot_fired), 0);
        applyStimulus(0, 1, 0, 100, 8, 0, 0, 0);
        applyStimulus(1, 0, 0, 100, 8, 0, 0, 0);
        checkVal("top.refire_shot", int'(shot_fired), 1);
        checkVal("top.refire_y", int'(y_bullet), 4);
        drainToIdle("drain2");

        // Fire held through a whole flight: 100 edges to return to IDLE.
        shots = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1, 1, 0, 320, 300, 0, 10'(mX), 10'(mY));
            checkOutput("held");
            if (shot_fired) shots++;
        end
        checkVal("held.shot_count", shots, 1);
        applyStimulus(1, 1, 0, 320, 300, 0, 0, 0);
        checkVal("held.second_shot", int'(shot_fired), 1);
        checkOutput("held2");
        drainToIdle("drain3");

        // Spawn overflow to the right, then underflow to the left.
        applyStimulus(1, 0, 0, 610, 200, 3, 0, 0);
        checkVal("ovf.shot", int'(shot_fired), 1);
        checkVal("ovf.active", int'(bullet_active), 0);
        checkVal("ovf.x", int'(x_bullet), 636);
        checkVal("ovf.y", int'(y_bullet), 214);
        actSeen = 0;
        for (int k = 0; k < 24; k++) begin
            tickCycle("ovf");
            if (bullet_active) actSeen = 1;
        end
        checkVal("ovf.never_active", actSeen, 0);
        drainToIdle("drain4");
        applyStimulus(1, 0, 0, 2, 100, 2, 0, 0);
        checkOutput("unf");
        drainToIdle("drain5");

        // Async reset between edges while flying.
        applyStimulus(1, 0, 0, 200, 200, 2, 196, 214);
        checkOutput("rst.spawn");
        applyStimulus(0, 1, 0, 200, 200, 2, 192, 214);
        checkOutput("rst.fly");
        #3;
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("rst.x", int'(x_bullet), 0);
        checkVal("rst.y", int'(y_bullet), 0);
        checkVal("rst.active", int'(bullet_active), 0);
        checkVal("rst.bullet_on", int'(bullet_on), 0);
        checkVal("rst.shot", int'(shot_fired), 0);
        @(posedge clk_50MHz);
        #1;
        reset = 1'b0;
        checkOutput("rst.after");

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rxs = 10'($urandom_range(590, 620));
                rys = 10'($urandom_range(0, 8));
            end else begin
                rxs = 10'($urandom_range(0, 608));
                rys = 10'($urandom_range(0, 460));
            end
            pxi = mX - 8 + int'($urandom_range(0, 24));
            pyi = mY - 8 + int'($urandom_range(0, 24));
            if (pxi < 0) pxi = 0;
            if (pyi < 0) pyi = 0;
            rpx = 10'(pxi);
            rpy = 10'(pyi);
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 15) == 0), rxs, rys,
                          2'($urandom_range(0, 3)), rpx, rpy);
            checkOutput("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
